remote_rom_server: RTL and testbench

REMOTE_ROM_SERVER -- requirements
Module: remote_rom_server

---
 rtl/remote_rom_pkg.sv | 13 +
 rtl/byte_shifter.sv | 34 +++
 rtl/remote_rom_server.sv | 126 ++++++++++++
 tb/tb_remote_rom_server.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/remote_rom_pkg.sv
// rtl/remote_rom_pkg.sv - shared state encoding and default sizing for the remote ROM server
package remote_rom_pkg;

    localparam int DEFAULT_NBYTES = 8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_MEM  = 2'd2,
        S_RESP = 2'd3
    } state_t;

endpackage

// File: rtl/byte_shifter.sv
// rtl/byte_shifter.sv - byte-wide shift register with parallel load, LSB-first shift in and out
module byte_shifter #(
    parameter int NBYTES = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [8*NBYTES-1:0]   load_value,
    input  logic                  shift_in,
    input  logic [7:0]            in_byte,
    input  logic                  shift_out,
    output logic [8*NBYTES-1:0]   value,
    output logic [7:0]            out_byte
);

    localparam int W = 8 * NBYTES;

    // New bytes enter at the top so the first byte received ends up in [7:0]
    // after NBYTES shifts; shifting out presents bytes LSB first on out_byte.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value <= '0;
        end else if (load) begin
            value <= load_value;
        end else if (shift_in) begin
            value <= {in_byte, value[W-1:8]};
        end else if (shift_out) begin
            value <= {8'h00, value[W-1:8]};
        end
    end

    assign out_byte = value[7:0];

endmodule

// File: rtl/remote_rom_server.sv
// rtl/remote_rom_server.sv - pops an address from a command FIFO, reads memory, pushes the data bytes out
module remote_rom_server
    import remote_rom_pkg::*;
#(
    parameter int NBYTES = DEFAULT_NBYTES
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        empty,
    output logic        rd_en,
    input  logic [7:0]  dout,
    input  logic        full,
    output logic        wr_en,
    output logic [7:0]  din,
    output logic        mem_req,
    output logic [63:0] mem_addr,
    input  logic        mem_ack,
    input  logic [63:0] mem_data,
    output logic        busy
);

    localparam int              CW       = $clog2(NBYTES) + 1;
    localparam logic [CW-1:0]   CNT_MAX  = CW'(NBYTES);
    localparam logic [CW-1:0]   CNT_LAST = CW'(NBYTES - 1);

    state_t              state;
    logic [CW-1:0]       pop_cnt;
    logic [CW-1:0]       cap_cnt;
    logic [CW-1:0]       push_cnt;
    logic                capture;
    logic                mem_fire;
    logic                last_capture;
    logic                last_push;
    logic [8*NBYTES-1:0] addr_value;
    logic [8*NBYTES-1:0] data_value;
    logic [7:0]          addr_out_byte;
    logic                unused_bits;

    // Pops and pushes follow the FIFO flags directly so the server can move one byte per cycle.
    assign rd_en        = (state == S_ADDR) && !empty && (pop_cnt < CNT_MAX);
    assign wr_en        = (state == S_RESP) && !full;
    assign mem_fire     = (state == S_MEM) && mem_ack;
    assign last_capture = capture && (cap_cnt == CNT_LAST);
    assign last_push    = wr_en && (push_cnt == CNT_LAST);

    // S_IDLE is excluded so busy reads low while held in reset and during the start-up cycle.
    assign busy     = ((state != S_ADDR) && (state != S_IDLE)) || (pop_cnt != '0);
    assign mem_addr = 64'(addr_value);

    // Main control: counts pops, captures and pushes, and sequences the memory request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            pop_cnt  <= '0;
            cap_cnt  <= '0;
            push_cnt <= '0;
            capture  <= 1'b0;
            mem_req  <= 1'b0;
        end else begin
            capture <= rd_en;
            case (state)
                S_IDLE: begin
                    state <= S_ADDR;
                end
                S_ADDR: begin
                    if (rd_en) begin
                        pop_cnt <= pop_cnt + 1'b1;
                    end
                    if (capture) begin
                        cap_cnt <= cap_cnt + 1'b1;
                    end
                    if (last_capture) begin
                        state   <= S_MEM;
                        mem_req <= 1'b1;
                    end
                end
                S_MEM: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        state   <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (last_push) begin
                        state    <= S_ADDR;
                        pop_cnt  <= '0;
                        cap_cnt  <= '0;
                        push_cnt <= '0;
                    end else if (wr_en) begin
                        push_cnt <= push_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    byte_shifter #(.NBYTES(NBYTES)) u_addr_shifter (
        .clk        (clk),
        .rst        (rst),
        .load       (1'b0),
        .load_value ('0),
        .shift_in   (capture),
        .in_byte    (dout),
        .shift_out  (1'b0),
        .value      (addr_value),
        .out_byte   (addr_out_byte)
    );

    byte_shifter #(.NBYTES(NBYTES)) u_data_shifter (
        .clk        (clk),
        .rst        (rst),
        .load       (mem_fire),
        .load_value (mem_data[8*NBYTES-1:0]),
        .shift_in   (1'b0),
        .in_byte    (8'h00),
        .shift_out  (wr_en),
        .value      (data_value),
        .out_byte   (din)
    );

    assign unused_bits = ^{addr_out_byte, data_value[8*NBYTES-1:8]};

endmodule

// File: tb/tb_remote_rom_server.sv
// tb/tb_remote_rom_server.sv - scoreboard bench for remote_rom_server
module tb_remote_rom_server;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        empty;
    logic        rd_en;
    logic [7:0]  dout = 8'h00;
    logic        full = 1'b0;
    logic        wr_en;
    logic [7:0]  din;
    logic        mem_req;
    logic [63:0] mem_addr;
    logic        mem_ack = 1'b0;
    logic [63:0] mem_data = 64'h0;
    logic        busy;

    always #5 clk = ~clk;

    remote_rom_server #(.NBYTES(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .empty    (empty),
        .rd_en    (rd_en),
        .dout     (dout),
        .full     (full),
        .wr_en    (wr_en),
        .din      (din),
        .mem_req  (mem_req),
        .mem_addr (mem_addr),
        .mem_ack  (mem_ack),
        .mem_data (mem_data),
        .busy     (busy)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [63:0] exp_addr_q[$];
    logic [63:0] data_q[$];
    logic [7:0]  exp_resp_q[$];

    int ack_delay = 2;
    int wait_cnt = 0;
    int ack_cycle = -100;
    int last_rd_cycle = -100;
    int last_push_cycle = -100;
    int push_idx = 0;
    int pop_total = 0;
    int pop_in_txn = 0;
    int b2b_start = 0;
    int stray_req_n = 0;
    int stray_done = 0;
    logic b2b_check = 1'b0;
    logic mem_active = 1'b0;
    logic full_prev = 1'b0;
    logic toggle_en = 1'b0;
    logic hold_empty = 1'b0;
    logic [7:0]  prev_din = 8'h00;
    logic [63:0] cur_addr = 64'h0;
    logic [63:0] cur_data = 64'h0;

    logic [7:0] cmd_mem [0:255];
    int cmd_wr = 0;
    int cmd_rd = 0;

    assign empty = (cmd_wr == cmd_rd) || hold_empty;

    always @(posedge clk) cyc <= cyc + 1;

    // command FIFO model: data appears on dout the cycle after rd_en
    always @(posedge clk) begin
        if (rd_en) begin
            dout   <= cmd_mem[cmd_rd[7:0]];
            cmd_rd <= cmd_rd + 1;
        end
    end

    always @(posedge clk) begin
        #1;
        if (toggle_en) hold_empty = ~hold_empty;
        else           hold_empty = 1'b0;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_bytes(input logic [63:0] a, input int n);
        @(posedge clk); #1;
        for (int i = 0; i < n; i++) begin
            cmd_mem[cmd_wr[7:0]] = a[8*i +: 8];
            cmd_wr++;
        end
    endtask

    task automatic txn(input logic [63:0] a, input logic [63:0] d);
        exp_addr_q.push_back(a);
        data_q.push_back(d);
        for (int i = 0; i < 8; i++) exp_resp_q.push_back(d[8*i +: 8]);
        push_bytes(a, 8);
    endtask

    task automatic wait_idle(input string name);
        logic done;
        done = 1'b0;
        for (int i = 0; i < 3000 && !done; i++) begin
            @(negedge clk); #1;
            if (exp_resp_q.size() == 0 && exp_addr_q.size() == 0 && !mem_req && !busy) done = 1'b1;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: %0d bytes still expected", name, exp_resp_q.size());
        end
        repeat (2) @(negedge clk);
    endtask

    // monitor: pop/push/memory checks against the scoreboard, plus the memory responder
    always @(negedge clk) begin
        if (rst) begin
            pop_in_txn = 0;
            mem_active = 1'b0;
            mem_ack    = 1'b0;
            full_prev  = 1'b0;
        end else begin
            if (rd_en) begin
                check("rd_en_while_empty", empty, 1'b0);
                if (b2b_check && pop_in_txn == 0 && last_push_cycle > b2b_start)
                    check("b2b_pop_cycle", cyc, last_push_cycle + 1);
                last_rd_cycle = cyc;
                pop_total++;
                pop_in_txn = (pop_in_txn == 7) ? 0 : pop_in_txn + 1;
            end

            if (full) check("wr_en_while_full", wr_en, 1'b0);
            if (full && full_prev) check("din_hold_on_full", din, prev_din);
            if (wr_en) begin
                if (exp_resp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_push: din %0h with nothing expected", din);
                end else begin
                    check("resp_byte", din, exp_resp_q.pop_front());
                end
                if (push_idx % 8 == 0) check("ack_to_push_latency", cyc, ack_cycle + 1);
                if (push_idx % 8 == 7) last_push_cycle = cyc;
                push_idx++;
            end
            full_prev = full;
            prev_din  = din;

            if (mem_ack) begin
                mem_ack = 1'b0;
                if (mem_active) check("mem_req_drop", mem_req, 1'b0);
                mem_active = 1'b0;
            end else if (mem_req) begin
                if (!mem_active) begin
                    mem_active = 1'b1;
                    wait_cnt   = 0;
                    check("req_latency", cyc, last_rd_cycle + 2);
                    if (exp_addr_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_mem_req: addr %0h", mem_addr);
                        cur_addr = mem_addr;
                        cur_data = 64'h0;
                    end else begin
                        cur_addr = exp_addr_q.pop_front();
                        cur_data = data_q.pop_front();
                    end
                end
                check("mem_addr", mem_addr, cur_addr);
                check("busy_in_mem", busy, 1'b1);
                if (wait_cnt == ack_delay) begin
                    mem_ack   = 1'b1;
                    mem_data  = cur_data;
                    ack_cycle = cyc;
                end else begin
                    wait_cnt++;
                end
            end else if (stray_done < stray_req_n) begin
                stray_done++;
                mem_ack  = 1'b1;
                mem_data = 64'hDEAD_BEEF_0BAD_F00D;
            end
        end
    end

    initial begin
        int base;
        logic reached;

        // reset values
        repeat (3) @(negedge clk);
        check("rst_rd_en", rd_en, 1'b0);
        check("rst_wr_en", wr_en, 1'b0);
        check("rst_mem_req", mem_req, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_din", din, 8'h00);
        check("rst_mem_addr", mem_addr, 64'h0);
        @(posedge clk); #1 rst = 1'b0;
        repeat (3) @(negedge clk);
        check("idle_busy", busy, 1'b0);

        // basic transaction
        txn(64'hEFCD_AB89_6745_2301, 64'h1122_3344_5566_7788);
        wait_idle("basic");

        // empty toggling every other cycle
        base = pop_total;
        toggle_en = 1'b1;
        txn(64'hEFCD_AB89_6745_2301, 64'h0807_0605_0403_0201);
        wait_idle("toggle_empty");
        toggle_en = 1'b0;
        check("toggle_pop_count", pop_total - base, 8);

        // full held for 5 cycles after the 3rd response byte
        base = push_idx;
        txn(64'h0000_0000_DEAD_BEEF, 64'hA0A1_A2A3_A4A5_A6A7);
        reached = 1'b0;
        for (int i = 0; i < 500 && !reached; i++) begin
            @(negedge clk); #1;
            if (push_idx >= base + 3) reached = 1'b1;
        end
        check("full_test_reached", reached, 1'b1);
        @(posedge clk); #1 full = 1'b1;
        repeat (5) @(posedge clk);
        #1 full = 1'b0;
        wait_idle("full_stall");
        check("full_push_count", push_idx - base, 8);

        // slow memory, then a stray ack while waiting for commands
        ack_delay = 20;
        txn(64'h1357_9BDF_0246_8ACE, 64'hFEDC_BA98_7654_3210);
        wait_idle("slow_mem");
        ack_delay = 2;
        base = push_idx;
        stray_req_n++;
        repeat (6) @(negedge clk);
        check("stray_ack_no_push", push_idx, base);
        check("stray_ack_no_req", mem_req, 1'b0);

        // reset after four address bytes
        base = pop_total;
        push_bytes(64'h0000_0000_CAFE_F00D, 4);
        reached = 1'b0;
        for (int i = 0; i < 100 && !reached; i++) begin
            @(negedge clk); #1;
            if (pop_total >= base + 4) reached = 1'b1;
        end
        check("partial_pops", reached, 1'b1);
        repeat (2) @(negedge clk);
        check("busy_partial", busy, 1'b1);
        @(posedge clk); #1 rst = 1'b1;
        #1;
        check("abort_rd_en", rd_en, 1'b0);
        check("abort_wr_en", wr_en, 1'b0);
        check("abort_mem_req", mem_req, 1'b0);
        check("abort_busy", busy, 1'b0);
        check("abort_din", din, 8'h00);
        check("abort_mem_addr", mem_addr, 64'h0);
        txn(64'h0123_4567_89AB_CDEF, 64'h0F1E_2D3C_4B5A_6978);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("idle_cycle_no_pop", rd_en, 1'b0);
        @(negedge clk);
        check("first_pop_after_idle", rd_en, 1'b1);
        wait_idle("after_reset");

        // back-to-back transactions
        ack_delay = 0;
        b2b_start = cyc;
        b2b_check = 1'b1;
        txn(64'h1111_2222_3333_4444, 64'hC0C1_C2C3_C4C5_C6C7);
        txn(64'h5555_6666_7777_8888, 64'hD0D1_D2D3_D4D5_D6D7);
        wait_idle("back_to_back");
        b2b_check = 1'b0;

        check("total_pops", pop_total, 60);
        check("total_pushes", push_idx, 56);
        check("resp_queue_drained", exp_resp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
